branch_resolve_unit: RTL and testbench

//  Decode-stage branch resolver for the MIPS pipeline: decodes the branch opcode into a compare op, compares

---
 rtl/branch_resolve_unit_pkg.sv | 41 ++++
 rtl/branch_resolve_unit_bht.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 183 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the decode-stage branch resolver: compare-op codes,
// MIPS opcode / REGIMM rt encodings, BHT reset value and counter helpers.
package branch_resolve_unit_pkg;

  // Compare-op codes presented on CMP_Op
  localparam logic [2:0] CMP_OP_EQ   = 3'b000;
  localparam logic [2:0] CMP_OP_GTZ  = 3'b001;
  localparam logic [2:0] CMP_OP_LEZ  = 3'b010;
  localparam logic [2:0] CMP_OP_NE   = 3'b011;
  localparam logic [2:0] CMP_OP_GEZ  = 3'b100;
  localparam logic [2:0] CMP_OP_LTZ  = 3'b101;
  localparam logic [2:0] CMP_OP_NONE = 3'b111;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;

  // REGIMM sub-codes carried in the rt field (Instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // Every BHT entry starts weakly not-taken
  localparam logic [1:0] BHT_INIT = 2'b01;

  // Saturating 2-bit counter step: up on taken (stops at 11), down otherwise (stops at 00)
  function automatic logic [1:0] bht_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: DEPTH x 2-bit saturating counters with a
// combinational read port and a single synchronous update port.
module bht_counter_array
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] upd_ctr_d;

  // Read is taken straight from the array, so a same-cycle update is not visible yet
  assign rd_ctr_o = ctr_q[rd_idx_i];

  // New value for the entry being trained
  always_comb begin
    upd_ctr_d = bht_step(ctr_q[upd_idx_i], upd_taken_i);
  end

  // Counter storage: async reset to weakly not-taken, write only the trained entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= upd_ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver: decodes the branch opcode, compares the
// forwarded operands, builds target/link addresses, predicts from the BHT
// and registers one resolved outcome per cycle for the fetch/PC logic.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instr_D,
  input  logic [ADDR_W-1:0] PC_D,
  input  logic [DATA_W-1:0] RS_D,
  input  logic [DATA_W-1:0] RT_D,
  input  logic              Valid_D,
  input  logic              Stall_D,
  input  logic              Flush,
  output logic [2:0]        CMP_Op,
  output logic              Pred_Taken,
  output logic              Br_Valid,
  output logic              Br_Taken,
  output logic [ADDR_W-1:0] Br_Target,
  output logic              Br_Link,
  output logic [ADDR_W-1:0] Link_Addr,
  output logic              Mispredict
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [ADDR_W-1:0] PC_PLUS4 = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] PC_PLUS8 = {{(ADDR_W-4){1'b0}}, 4'b1000};

  logic [5:0]        opc_s;
  logic [4:0]        rt_fld_s;
  logic [2:0]        cmp_op_s;
  logic              link_s;
  logic              taken_s;
  logic              rs_neg_s;
  logic              rs_zero_s;
  logic [ADDR_W-1:0] imm_ext_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] link_addr_s;
  logic [IDX_W-1:0]  bht_idx_s;
  logic [1:0]        bht_ctr_s;
  logic              pred_s;
  logic              br_valid_next_s;
  logic              bht_upd_s;
  logic              unused_rs_fld_s;

  logic              br_valid_q,  br_valid_d;
  logic              br_taken_q,  br_taken_d;
  logic [ADDR_W-1:0] br_target_q, br_target_d;
  logic              br_link_q,   br_link_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              mispred_q,   mispred_d;

  assign opc_s           = Instr_D[31:26];
  assign rt_fld_s        = Instr_D[20:16];
  assign unused_rs_fld_s = ^Instr_D[25:21];

  // Opcode decode to compare op; anything unrecognised is a defined no-branch
  always_comb begin
    cmp_op_s = CMP_OP_NONE;
    link_s   = 1'b0;
    case (opc_s)
      OPC_BEQ:  cmp_op_s = CMP_OP_EQ;
      OPC_BGTZ: cmp_op_s = CMP_OP_GTZ;
      OPC_BLEZ: cmp_op_s = CMP_OP_LEZ;
      OPC_BNE:  cmp_op_s = CMP_OP_NE;
      OPC_REGIMM: begin
        case (rt_fld_s)
          RT_BGEZ:   cmp_op_s = CMP_OP_GEZ;
          RT_BGEZAL: begin
            cmp_op_s = CMP_OP_GEZ;
            link_s   = 1'b1;
          end
          RT_BLTZ:   cmp_op_s = CMP_OP_LTZ;
          RT_BLTZAL: begin
            cmp_op_s = CMP_OP_LTZ;
            link_s   = 1'b1;
          end
          default:   cmp_op_s = CMP_OP_NONE;
        endcase
      end
      default: cmp_op_s = CMP_OP_NONE;
    endcase
  end

  assign CMP_Op    = cmp_op_s;
  assign rs_neg_s  = RS_D[DATA_W-1];
  assign rs_zero_s = (RS_D == {DATA_W{1'b0}});

  // Signed outcome: eq/ne compare RS with RT, the rest test RS against zero via sign/zero flags
  always_comb begin
    taken_s = 1'b0;
    case (cmp_op_s)
      CMP_OP_EQ:  taken_s = (RS_D == RT_D);
      CMP_OP_NE:  taken_s = (RS_D != RT_D);
      CMP_OP_GTZ: taken_s = !rs_neg_s && !rs_zero_s;
      CMP_OP_LEZ: taken_s = rs_neg_s || rs_zero_s;
      CMP_OP_GEZ: taken_s = !rs_neg_s;
      CMP_OP_LTZ: taken_s = rs_neg_s;
      default:    taken_s = 1'b0;
    endcase
  end

  // Target and link addresses; sign-extend before the shift so negative offsets wrap correctly
  assign imm_ext_s   = {{(ADDR_W-16){Instr_D[15]}}, Instr_D[15:0]};
  assign target_s    = PC_D + PC_PLUS4 + (imm_ext_s << 2);
  assign link_addr_s = PC_D + PC_PLUS8;

  // Prediction: only real branches consult the table
  assign bht_idx_s       = PC_D[2 +: IDX_W];
  assign pred_s          = (cmp_op_s != CMP_OP_NONE) && bht_ctr_s[1];
  assign Pred_Taken      = pred_s;
  assign br_valid_next_s = Valid_D && (cmp_op_s != CMP_OP_NONE) && !Flush;
  assign bht_upd_s       = !Stall_D && br_valid_next_s;

  bht_counter_array #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (bht_idx_s),
    .rd_ctr_o    (bht_ctr_s),
    .upd_en_i    (bht_upd_s),
    .upd_idx_i   (bht_idx_s),
    .upd_taken_i (taken_s)
  );

  // Resolve register next state: load when not stalled, flush kills even under stall, else hold
  always_comb begin
    br_valid_d  = br_valid_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    br_link_d   = br_link_q;
    link_addr_d = link_addr_q;
    mispred_d   = mispred_q;
    if (!Stall_D) begin
      br_valid_d  = br_valid_next_s;
      br_taken_d  = taken_s;
      br_target_d = target_s;
      br_link_d   = link_s;
      link_addr_d = link_addr_s;
      mispred_d   = br_valid_next_s && (taken_s != pred_s);
    end else if (Flush) begin
      br_valid_d = 1'b0;
      mispred_d  = 1'b0;
    end else begin
      br_valid_d = br_valid_q;
      mispred_d  = mispred_q;
    end
  end

  // Resolve register storage with async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= {ADDR_W{1'b0}};
      br_link_q   <= 1'b0;
      link_addr_q <= {ADDR_W{1'b0}};
      mispred_q   <= 1'b0;
    end else begin
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      br_link_q   <= br_link_d;
      link_addr_q <= link_addr_d;
      mispred_q   <= mispred_d;
    end
  end

  assign Br_Valid   = br_valid_q;
  assign Br_Taken   = br_taken_q;
  assign Br_Target  = br_target_q;
  assign Br_Link    = br_link_q;
  assign Link_Addr  = link_addr_q;
  assign Mispredict = mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push their
// hand-computed registered response; a monitor pops one entry per cycle.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_D, PC_D, RS_D, RT_D;
  logic        Valid_D, Stall_D, Flush;
  logic [2:0]  CMP_Op;
  logic        Pred_Taken, Br_Valid, Br_Taken, Br_Link, Mispredict;
  logic [31:0] Br_Target, Link_Addr;

  typedef struct {
    logic        full;
    logic        valid;
    logic        taken;
    logic [31:0] target;
    logic        link;
    logic [31:0] la;
    logic        mis;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BLEZ = 6'b000110,
                         BGTZ = 6'b000111, RIMM = 6'b000001;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .PC_D(PC_D), .RS_D(RS_D), .RT_D(RT_D),
    .Valid_D(Valid_D), .Stall_D(Stall_D), .Flush(Flush), .CMP_Op(CMP_Op),
    .Pred_Taken(Pred_Taken), .Br_Valid(Br_Valid), .Br_Taken(Br_Taken),
    .Br_Target(Br_Target), .Br_Link(Br_Link), .Link_Addr(Link_Addr),
    .Mispredict(Mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd3, rt, imm};
  endfunction

  // Drive one D-stage vector, check the combinational outputs, queue the registered response
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic v, input logic st, input logic fl,
                       input logic [2:0] ecmp, input logic epred,
                       input logic ev, input logic et, input logic [31:0] etgt,
                       input logic el, input logic em);
    exp_t e;
    @(posedge clk);
    #2;
    Instr_D = instr; PC_D = pc; RS_D = rs; RT_D = rt;
    Valid_D = v; Stall_D = st; Flush = fl;
    #1;
    chk("cmp_op", {29'd0, CMP_Op}, {29'd0, ecmp});
    chk("pred_taken", {31'd0, Pred_Taken}, {31'd0, epred});
    if (st && !fl) begin
      e = last_exp;
    end else if (st) begin
      e = last_exp;
      e.valid = 1'b0; e.mis = 1'b0; e.full = 1'b0;
    end else begin
      e.full = ev; e.valid = ev; e.taken = et; e.target = etgt;
      e.link = el; e.la = pc + 32'd8; e.mis = em;
    end
    last_exp = e;
    q.push_back(e);
  endtask

  // Monitor: one captured response per cycle, compared after the edge settles
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("br_valid", {31'd0, Br_Valid}, {31'd0, mon_e.valid});
      chk("mispredict", {31'd0, Mispredict}, {31'd0, mon_e.mis});
      if (mon_e.full) begin
        chk("br_taken", {31'd0, Br_Taken}, {31'd0, mon_e.taken});
        chk("br_target", Br_Target, mon_e.target);
        chk("br_link", {31'd0, Br_Link}, {31'd0, mon_e.link});
        chk("link_addr", Link_Addr, mon_e.la);
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, Br_Valid}, 32'd0);
    chk({tag, "_taken"}, {31'd0, Br_Taken}, 32'd0);
    chk({tag, "_target"}, Br_Target, 32'd0);
    chk({tag, "_link"}, {31'd0, Br_Link}, 32'd0);
    chk({tag, "_link_addr"}, Link_Addr, 32'd0);
    chk({tag, "_mis"}, {31'd0, Mispredict}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    Instr_D = 32'd0; PC_D = 32'd0; RS_D = 32'd0; RT_D = 32'd0;
    Valid_D = 1'b0; Stall_D = 1'b0; Flush = 1'b0;
    last_exp = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_state("init");

    //    instr                      pc         rs           rt     v  st fl cmp     pr ev et target        lk mis
    issue(mk(BEQ, 5'd0, 16'h0003),   32'h100, 32'd5,       32'd5, 1, 0, 0, 3'b000, 0, 1, 1, 32'h110,      0, 1);
    issue(mk(BEQ, 5'd0, 16'h0003),   32'h100, 32'd5,       32'd5, 1, 0, 0, 3'b000, 1, 1, 1, 32'h110,      0, 0);
    issue(mk(BEQ, 5'd0, 16'h0003),   32'h100, 32'd5,       32'd5, 1, 0, 0, 3'b000, 1, 1, 1, 32'h110,      0, 0);
    issue(mk(BEQ, 5'd0, 16'h0003),   32'h100, 32'd5,       32'd6, 1, 0, 0, 3'b000, 1, 1, 0, 32'h110,      0, 1);
    issue(mk(RIMM, 5'b10001, 16'h0010), 32'h204, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 3'b100, 0, 1, 0, 32'h248, 1, 0);
    issue(mk(BLEZ, 5'd0, 16'hFFFF),  32'h308, 32'd0,       32'd9, 1, 0, 0, 3'b010, 0, 1, 1, 32'h308,      0, 1);
    issue(mk(BGTZ, 5'd0, 16'h0001),  32'h40C, 32'd1,       32'd0, 1, 0, 0, 3'b001, 0, 1, 1, 32'h414,      0, 1);
    issue(mk(RIMM, 5'b00000, 16'h0002), 32'h510, 32'h80000000, 32'd7, 1, 0, 0, 3'b101, 0, 1, 1, 32'h51C, 0, 1);
    issue(mk(BNE, 5'd0, 16'h0004),   32'h614, 32'd1,       32'd2, 1, 1, 0, 3'b011, 0, 0, 0, 32'h0,        0, 0);
    issue(mk(BNE, 5'd0, 16'h0004),   32'h614, 32'd1,       32'd2, 1, 0, 0, 3'b011, 0, 1, 1, 32'h628,      0, 1);
    issue(mk(BNE, 5'd0, 16'h0004),   32'h614, 32'd1,       32'd2, 1, 1, 1, 3'b011, 1, 0, 0, 32'h0,        0, 0);
    issue(mk(BNE, 5'd0, 16'h0004),   32'h614, 32'd3,       32'd3, 1, 0, 0, 3'b011, 1, 1, 0, 32'h628,      0, 1);
    issue(32'h00221821,              32'h100, 32'd0,       32'd0, 1, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0, 0);
    issue(mk(BEQ, 5'd0, 16'h0003),   32'h100, 32'd1,       32'd1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h0,        0, 0);
    issue(mk(BEQ, 5'd0, 16'h0003),   32'h100, 32'd1,       32'd1, 1, 0, 0, 3'b000, 1, 1, 1, 32'h110,      0, 0);
    issue(mk(BEQ, 5'd0, 16'h8000),   32'h010, 32'd0,       32'd0, 1, 0, 0, 3'b000, 1, 1, 1, 32'hFFFE0014, 0, 0);
    issue(mk(RIMM, 5'b00010, 16'h0001), 32'h204, 32'd0,    32'd0, 1, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0, 0);
    issue(mk(BEQ, 5'd0, 16'h0000),   32'h204, 32'd0,       32'd0, 1, 0, 1, 3'b000, 0, 0, 0, 32'h0,        0, 0);
    issue(mk(RIMM, 5'b00001, 16'h0000), 32'h204, 32'd0,    32'd0, 1, 0, 0, 3'b100, 0, 1, 1, 32'h208,      0, 1);

    // Async reset in the middle of a stalled taken branch whose entry is strongly taken
    @(posedge clk);
    #2;
    Instr_D = mk(BEQ, 5'd0, 16'h0003); PC_D = 32'h100; RS_D = 32'd1; RT_D = 32'd1;
    Valid_D = 1'b1; Stall_D = 1'b1; Flush = 1'b0;
    #1 chk("pre_reset_pred", {31'd0, Pred_Taken}, 32'd1);
    #1 reset = 1'b1;
    #1 chk_reset_state("midreset");
    chk("midreset_pred", {31'd0, Pred_Taken}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    last_exp = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      issue(mk(BEQ, 5'd0, 16'h0000), 32'(i * 4), 32'd0, 32'd0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 0, 0);
    end
    issue(mk(BEQ, 5'd0, 16'h0003), 32'h100, 32'd0, 32'd0, 1, 0, 0, 3'b000, 0, 1, 1, 32'h110, 0, 1);
    issue(mk(BEQ, 5'd0, 16'h0003), 32'h100, 32'd0, 32'd0, 1, 0, 0, 3'b000, 1, 1, 1, 32'h110, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
